// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//
// Multi-channel push-button debouncer with press / release / long-press event
// pulses. Each key runs in its own key_debounce_chan instance; the channels
// share only the clock and reset, so events on several keys are all reported
// in the same clock.
//
// Parameters
//   N_KEYS        number of key channels (1..32)
//   STABLE_CYCLES consecutive stable clocks before a level change is accepted (>=2)
//   LONG_CYCLES   clocks a key must stay pressed before a long-press event (>=2)
//   ACTIVE_LOW    1: a raw 0 on key_in means pressed
//
// Ports
//   clk_100kHz    single clock, all state changes on its rising edge
//   rst_          asynchronous active-low reset
//   key_in        raw asynchronous key levels
//   key_out       debounced level per key, 1 = pressed
//   press_pulse   one-clock pulse on each accepted press
//   release_pulse one-clock pulse on each accepted release
//   long_pulse    one-clock pulse when a press has been held LONG_CYCLES clocks
//   key_any       registered OR of key_out (one clock behind key_out)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// key_debounce_chan
//
// One debounce channel: 2-flop synchroniser, stability counter, debounced
// level, hold counter and the three registered event pulses.
//
// Ports
//   clk_100kHz, rst_  clock and asynchronous active-low reset
//   i_raw             raw key level, already polarity-corrected (1 = pressed)
//   o_level           debounced level
//   o_press           pulse in the first clock o_level reads 1
//   o_release         pulse in the first clock o_level reads 0
//   o_long            pulse when the hold counter reaches LONG_CYCLES
// -----------------------------------------------------------------------------
module key_debounce_chan #(
  parameter int STABLE_CYCLES = 1000,
  parameter int LONG_CYCLES   = 100000
) (
  input  logic clk_100kHz,
  input  logic rst_,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  // The counter holds the number of mismatching edges already seen, so the
  // STABLE_CYCLES-th mismatching edge is the one where it reads STABLE_CYCLES-1.
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [SW-1:0] r_stab;
  logic [HW-1:0] r_hold;
  logic          r_press;
  logic          r_release;
  logic          r_long;

  logic          w_diff;
  logic          w_accept;
  logic          w_press_acc;
  logic          w_rel_acc;
  logic          w_hold_inc;

  assign w_diff      = r_s2 ^ r_level;
  assign w_accept    = w_diff && (r_stab == STAB_LAST);
  assign w_press_acc = w_accept && r_s2;
  assign w_rel_acc   = w_accept && !r_s2;
  // No counting on the edge that accepts a release, so a release landing on
  // the last hold clock cannot produce a long-press event.
  assign w_hold_inc  = r_level && !w_rel_acc && (r_hold != HOLD_MAX);

  // Synchroniser.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Stability counter: any edge where the synchronised input agrees with the
  // debounced level restarts the count, so only an unbroken run is accepted.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      r_stab <= '0;
    end else if (!w_diff || w_accept) begin
      r_stab <= '0;
    end else begin
      r_stab <= r_stab + 1'b1;
    end
  end

  // Debounced level.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      r_level <= 1'b0;
    end else if (w_accept) begin
      r_level <= r_s2;
    end
  end

  // Hold counter: restarted by an accepted press, saturates at LONG_CYCLES so
  // the long-press event cannot repeat within one press.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      r_hold <= '0;
    end else if (w_press_acc) begin
      r_hold <= '0;
    end else if (w_hold_inc) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Event pulses, registered alongside the level so each pulse is high in
  // exactly the clock the new level (or saturated hold count) first appears.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_press   <= w_press_acc;
      r_release <= w_rel_acc;
      r_long    <= r_level && !w_rel_acc && (r_hold == HOLD_LAST);
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

module key_debounce_multi #(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 1000,
  parameter int LONG_CYCLES   = 100000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic              clk_100kHz,
  input  logic              rst_,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic              key_any
);

  logic [N_KEYS-1:0] w_raw;
  logic              r_key_any;

  // Polarity is fixed ahead of the synchroniser so everything downstream
  // works in "1 = pressed".
  assign w_raw = ACTIVE_LOW ? ~key_in : key_in;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES)
    ) u_chan (
      .clk_100kHz (clk_100kHz),
      .rst_       (rst_),
      .i_raw      (w_raw[g]),
      .o_level    (key_out[g]),
      .o_press    (press_pulse[g]),
      .o_release  (release_pulse[g]),
      .o_long     (long_pulse[g])
    );
  end

  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      r_key_any <= 1'b0;
    end else begin
      r_key_any <= |key_out;
    end
  end

  assign key_any = r_key_any;

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;
  localparam int NK = 2;
  localparam int SC = 4;
  localparam int LC = 10;

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_out, press_pulse, release_pulse, long_pulse;
  logic          key_any;

  int checks = 0;
  int failures = 0;

  key_debounce_multi #(
    .N_KEYS(NK), .STABLE_CYCLES(SC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk_100kHz    (clk),
    .rst_          (rst_),
    .key_in        (key_in),
    .key_out       (key_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .key_any       (key_any)
  );

  always #5 clk = ~clk;

  // Reference model. A level change is accepted when the last SC synchronised
  // samples (raw input delayed two clocks) all differ from the current level
  // and at least SC clocks have passed since the previous change. A long press
  // is reported when the level has been 1 for exactly LC clocks since the press.
  logic [NK-1:0] m_out, m_press, m_rel, m_long;
  logic          m_any;
  int            m_since[NK];
  int            m_held[NK];
  bit            m_hist[NK][$];

  wire [4*NK:0] w_dut = {key_any, long_pulse, release_pulse, press_pulse, key_out};
  wire [4*NK:0] w_mod = {m_any, m_long, m_rel, m_press, m_out};

  task automatic model_reset();
    m_out = '0; m_press = '0; m_rel = '0; m_long = '0; m_any = 1'b0;
    for (int k = 0; k < NK; k++) begin
      m_hist[k].delete();
      repeat (SC + 2) m_hist[k].push_back(1'b0);
      m_since[k] = 0;
      m_held[k] = 0;
    end
  endtask

  task automatic model_step();
    bit all_diff;
    m_any = |m_out;
    for (int k = 0; k < NK; k++) begin
      m_hist[k].push_back(key_in[k]);
      void'(m_hist[k].pop_front());
      m_since[k]++;
      all_diff = 1'b1;
      for (int j = 0; j < SC; j++) if (m_hist[k][j] == m_out[k]) all_diff = 1'b0;
      m_press[k] = 1'b0; m_rel[k] = 1'b0; m_long[k] = 1'b0;
      if (all_diff && m_since[k] >= SC) begin
        m_out[k] = ~m_out[k];
        m_since[k] = 0;
        if (m_out[k]) begin m_press[k] = 1'b1; m_held[k] = 0; end
        else m_rel[k] = 1'b1;
      end else if (m_out[k]) begin
        m_held[k]++;
        if (m_held[k] == LC) m_long[k] = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_);
      if (!rst_) model_reset();
      else model_step();
    end
  end

  task automatic test_reset();
    key_in = 2'b11;
    #1 rst_ = 1'b0;
    #1;
    checks++;
    if (w_dut !== '0) begin failures++; $display("FAIL reset_async got=%b exp=0", w_dut); end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (w_dut !== '0) begin failures++; $display("FAIL reset_hold got=%b exp=0", w_dut); end
    end
    rst_ = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL reset_model e=%0d got=%b exp=%b", e, w_dut, w_mod); end
      checks++;
      if (press_pulse !== ((e == 6) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL reset_press e=%0d got=%b", e, press_pulse);
      end
      checks++;
      if (key_out !== ((e >= 6) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL reset_keyout e=%0d got=%b", e, key_out);
      end
    end
  endtask

  task automatic test_release_all();
    key_in = 2'b00;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL release_model e=%0d got=%b exp=%b", e, w_dut, w_mod); end
      checks++;
      if (release_pulse !== ((e == 6) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL release_pulse e=%0d got=%b", e, release_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    bit seen = 1'b0;
    for (int e = 0; e < 32; e++) begin
      key_in[0] = (e < 20) ? ((e / 2) % 2 == 1) : 1'b0;
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL bounce_model e=%0d got=%b exp=%b", e, w_dut, w_mod); end
      if (key_out[0] || press_pulse[0] || release_pulse[0]) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL bounce_quiet got=activity exp=none"); end
  endtask

  task automatic test_clean();
    int np = 0, nr = 0, nl = 0;
    key_in[0] = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL clean_model e=%0d got=%b exp=%b", e, w_dut, w_mod); end
      checks++;
      if (key_out[0] !== (e >= 6 && e < 14)) begin
        failures++; $display("FAIL clean_level e=%0d got=%b", e, key_out[0]);
      end
      np += press_pulse[0]; nr += release_pulse[0]; nl += long_pulse[0];
      if (e == 8) key_in[0] = 1'b0;
    end
    checks++;
    if (np != 1 || nr != 1 || nl != 0) begin
      failures++; $display("FAIL clean_counts got=p%0d r%0d l%0d exp=p1 r1 l0", np, nr, nl);
    end
  endtask

  task automatic test_long();
    int nl = 0, nr = 0, le = 0;
    key_in[0] = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL long_model e=%0d got=%b exp=%b", e, w_dut, w_mod); end
      if (long_pulse[0]) begin nl++; le = e; end
      nr += release_pulse[0];
      if (e == 36) begin
        checks++;
        if (release_pulse[0] !== 1'b1) begin failures++; $display("FAIL long_release got=0 exp=1"); end
      end
      if (e == 30) key_in[0] = 1'b0;
    end
    checks++;
    if (nl != 1 || le != 16 || nr != 1) begin
      failures++; $display("FAIL long_counts got=l%0d at %0d r%0d exp=l1 at 16 r1", nl, le, nr);
    end
  endtask

  task automatic test_independence();
    bit ch0 = 1'b0;
    int np1 = 0;
    key_in = 2'b10;
    for (int e = 1; e <= 26; e++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL indep_model e=%0d got=%b exp=%b", e, w_dut, w_mod); end
      checks++;
      if (key_any !== (e >= 7 && e < 15)) begin
        failures++; $display("FAIL indep_any e=%0d got=%b", e, key_any);
      end
      if (key_out[0] || press_pulse[0] || release_pulse[0] || long_pulse[0]) ch0 = 1'b1;
      np1 += press_pulse[1];
      if (e == 8) key_in[1] = 1'b0;
      key_in[0] = (e < 20) ? ((e / 2) % 2 == 0) : 1'b0;
    end
    checks++;
    if (ch0 || np1 != 1) begin
      failures++; $display("FAIL indep_chan got=ch0act%0d p1=%0d exp=ch0act0 p1=1", ch0, np1);
    end
  endtask

  task automatic test_reset_mid_hold();
    int n = 0;
    key_in = 2'b01;
    while (key_out[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (key_out[0] !== 1'b1) begin failures++; $display("FAIL midhold_timeout got=%b exp=1", key_out[0]); end
    repeat (2) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if (w_dut !== '0) begin failures++; $display("FAIL midhold_async got=%b exp=0", w_dut); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (w_dut !== '0) begin failures++; $display("FAIL midhold_hold got=%b exp=0", w_dut); end
    end
    rst_ = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL midhold_model e=%0d got=%b exp=%b", e, w_dut, w_mod); end
      checks++;
      if (release_pulse !== 2'b00 || press_pulse !== ((e == 6) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL midhold_pulse e=%0d got=p%b r%b", e, press_pulse, release_pulse);
      end
    end
    key_in = 2'b00;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL midhold_tail got=%b exp=%b", w_dut, w_mod); end
    end
  endtask

  task automatic test_random();
    int run[NK];
    for (int k = 0; k < NK; k++) run[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (run[k] == 0) begin
          key_in[k] = $urandom_range(0, 1);
          run[k] = $urandom_range(1, 16);
        end
        run[k]--;
      end
      @(negedge clk);
      checks++;
      if (w_dut !== w_mod) begin failures++; $display("FAIL random_model c=%0d got=%b exp=%b", c, w_dut, w_mod); end
    end
  endtask

  initial begin
    test_reset();
    test_release_all();
    test_bounce();
    test_clean();
    test_long();
    test_independence();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
